regfile_seq: RTL and testbench
==============================

Name: regfile_seq

Overview:
- Micro-sequencer that drives the 8x16 register file's select, write-enable and write-data lines.
- Executes one register-mode command per start pulse: PC advance, then the operation, then a one-cycle done strobe.
- Sits between instruction decode and the register file; the register file's A/B read buses return combinationally into this block.
- Sole owner of the register file write port.

Parameters:
- PC_STEP, 2, amount added to R7 in the PC-advance cycle and by INC2/DEC2.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  command request; sampled only in IDLE.
- op  input  3  command: 0 MOV, 1 ADD, 2 SUB, 3 INC2, 4 DEC2, 5 SWAP, 6 CLR, 7 STEP.
- src  input  3  source register number.
- dst  input  3  destination register number.
- a_in  input  16  register file A bus, equal to R[sela].
- b_in  input  16  register file B bus, equal to R[selb].
- sela  output  3  register file A select.
- selb  output  3  register file B select, which is also the write address.
- we  output  1  register file write enable.
- w  output  16  register file write data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion strobe.
- result  output  16  last value written by the EXEC or SWAP2 state; held until the next write.
- flags  output  4  {N,Z,V,C} from the last EXEC; held otherwise.

Behaviour:
- Reset (reset=0, asynchronous):
  - state becomes IDLE.
  - sela, selb, w, result and flags become 0; we, busy and done become 0.
  - The latched command is cleared.
  - Reset mid-command abandons it with no further writes.
- States: IDLE, PCINC, EXEC, SWAP2, DONE.
- IDLE:
  - we=0, sela=selb=0, w=0.
  - start=1 at a posedge latches op, src and dst, then goes to PCINC.
  - start while busy is ignored; no queueing.
- PCINC: sela=7, selb=7, w=a_in+PC_STEP (mod 2^16), we=1. Next state is EXEC, or DONE when op=STEP.
- EXEC: sela=src, selb=dst, we=1. Write data by op:
  - MOV: w=a_in.
  - ADD: w=b_in+a_in.
  - SUB: w=b_in-a_in.
  - INC2: w=b_in+PC_STEP.
  - DEC2: w=b_in-PC_STEP.
  - CLR: w=0.
  - SWAP: w=a_in, and tmp<=b_in is latched.
- EXEC exit: result<=w. Next state is SWAP2 for SWAP, else DONE.
- Post-increment reads: in EXEC, a src or dst of 7 reads the already-incremented PC, because the PCINC write has landed.
- Flags, updated in EXEC only:
  - N = w[15]; Z = (w==0).
  - C = carry out of bit 15 for ADD/INC2; borrow for SUB/DEC2; 0 for other ops.
  - V = signed overflow for ADD/SUB/INC2/DEC2; 0 otherwise.
- SWAP2: sela=src, selb=src, w=tmp, we=1, result<=tmp. Next state is DONE.
  - SWAP with src==dst writes the original value twice; the register is unchanged.
- DONE: we=0, done=1 for exactly one cycle, then IDLE.
  - A start asserted during DONE is ignored; it must be held into IDLE to be taken.
- Latency from the start edge: STEP 2 cycles to done; MOV/ADD/SUB/INC2/DEC2/CLR 3 cycles; SWAP 4 cycles.
- Write count: exactly one write per busy cycle except DONE.
- Arithmetic: all arithmetic is 16-bit wrap-around; 0xFFFE+2 writes 0x0000 with C=1, Z=1.

Test Plan:
- Reset asserted mid-EXEC of ADD -> we drops to 0 immediately, busy=0, no dst write; next start runs normally.
- R7=0x0100, start op=STEP -> PCINC writes R7=0x0102; done on the 2nd cycle after start; R7 ends at 0x0102.
- R1=0x7FFF, R2=0x0001, ADD src=1 dst=2 -> R2=0x8000; flags N=1, Z=0, V=1, C=0; done 3 cycles after start.
- R3=0x1234, R4=0xABCD, SWAP src=3 dst=4 -> R4=0x1234, R3=0xABCD; 3 writes total; done 4 cycles after start.
- R7=0x0200, MOV src=7 dst=0 -> R0=0x0202 (post-incremented PC), R7=0x0202.
- R5=0x0000, DEC2 dst=5 -> R5=0xFFFE, C=1, N=1; a start pulse while busy is ignored, with no extra writes.

Source files
------------

// File: rtl/regfile_seq_if.sv
// Command, register-file and status signals of the micro-sequencer.
// The master modport is the sequencer side; the slave modport is decode plus the register file.
interface regfile_seq_if;
   logic        start;
   logic [2:0]  op;
   logic [2:0]  src;
   logic [2:0]  dst;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic [2:0]  sela;
   logic [2:0]  selb;
   logic        we;
   logic [15:0] w;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [3:0]  flags;

   modport master (
      input  start, op, src, dst, a_in, b_in,
      output sela, selb, we, w, busy, done, result, flags
   );

   modport slave (
      output start, op, src, dst, a_in, b_in,
      input  sela, selb, we, w, busy, done, result, flags
   );
endinterface

// File: rtl/regfile_seq.sv
// Register-mode micro-sequencer: for each accepted start it advances R7, runs one operation
// through the register file's single write port, then strobes done for one cycle.
module regfile_seq #(
   parameter int unsigned PC_STEP = 2
) (
   input  logic           clk,
   input  logic           reset,
   regfile_seq_if.master  bus
);
   typedef enum logic [2:0] {S_IDLE, S_PCINC, S_EXEC, S_SWAP2, S_DONE} state_t;

   localparam logic [2:0] OP_MOV  = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_INC2 = 3'd3;
   localparam logic [2:0] OP_DEC2 = 3'd4;
   localparam logic [2:0] OP_SWAP = 3'd5;
   localparam logic [2:0] OP_CLR  = 3'd6;
   localparam logic [2:0] OP_STEP = 3'd7;
   localparam logic [15:0] STEP_W = 16'(PC_STEP);

   state_t      state_reg, state_next;
   logic [2:0]  op_reg, src_reg, dst_reg;
   logic [15:0] tmp_reg, result_reg;
   logic [3:0]  flags_reg;

   logic [15:0] operand;
   logic [16:0] sum;
   logic        is_sub, is_arith, ovf;
   logic [15:0] exec_w;
   logic [3:0]  exec_flags;

   // One shared 17-bit adder/subtractor; bit 16 is carry for adds and borrow for subtracts.
   always_comb begin
      is_sub   = (op_reg == OP_SUB) || (op_reg == OP_DEC2);
      is_arith = (op_reg == OP_ADD) || (op_reg == OP_SUB) ||
                 (op_reg == OP_INC2) || (op_reg == OP_DEC2);
      operand  = ((op_reg == OP_ADD) || (op_reg == OP_SUB)) ? bus.a_in : STEP_W;
      sum      = is_sub ? ({1'b0, bus.b_in} - {1'b0, operand})
                        : ({1'b0, bus.b_in} + {1'b0, operand});
      ovf      = is_sub ? ((bus.b_in[15] != operand[15]) && (sum[15] != bus.b_in[15]))
                        : ((bus.b_in[15] == operand[15]) && (sum[15] != bus.b_in[15]));
      case (op_reg)
         OP_MOV, OP_SWAP:                  exec_w = bus.a_in;
         OP_ADD, OP_SUB, OP_INC2, OP_DEC2: exec_w = sum[15:0];
         default:                          exec_w = 16'h0000;
      endcase
      exec_flags = {exec_w[15], (exec_w == 16'h0000), is_arith & ovf, is_arith & sum[16]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= S_IDLE;
         op_reg     <= 3'd0;
         src_reg    <= 3'd0;
         dst_reg    <= 3'd0;
         tmp_reg    <= 16'h0000;
         result_reg <= 16'h0000;
         flags_reg  <= 4'h0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               if (bus.start) begin
                  op_reg  <= bus.op;
                  src_reg <= bus.src;
                  dst_reg <= bus.dst;
               end
            end
            S_EXEC: begin
               result_reg <= exec_w;
               flags_reg  <= exec_flags;
               if (op_reg == OP_SWAP) tmp_reg <= bus.b_in;
            end
            S_SWAP2: result_reg <= tmp_reg;
            default: ;
         endcase
      end
   end

   // Register-file controls are decoded from state so reset silences the write port at once.
   always_comb begin
      state_next = state_reg;
      bus.sela   = 3'd0;
      bus.selb   = 3'd0;
      bus.we     = 1'b0;
      bus.w      = 16'h0000;
      case (state_reg)
         S_IDLE: begin
            if (bus.start) state_next = S_PCINC;
         end
         S_PCINC: begin
            bus.sela   = 3'd7;
            bus.selb   = 3'd7;
            bus.we     = 1'b1;
            bus.w      = bus.a_in + STEP_W;
            state_next = (op_reg == OP_STEP) ? S_DONE : S_EXEC;
         end
         S_EXEC: begin
            bus.sela   = src_reg;
            bus.selb   = dst_reg;
            bus.we     = 1'b1;
            bus.w      = exec_w;
            state_next = (op_reg == OP_SWAP) ? S_SWAP2 : S_DONE;
         end
         S_SWAP2: begin
            bus.sela   = src_reg;
            bus.selb   = src_reg;
            bus.we     = 1'b1;
            bus.w      = tmp_reg;
            state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign bus.busy   = (state_reg != S_IDLE);
   assign bus.done   = (state_reg == S_DONE);
   assign bus.result = result_reg;
   assign bus.flags  = flags_reg;
endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: an 8x16 register file model closes the loop, directed commands push
// expected responses into a queue and a done-triggered monitor pops and checks them.
module tb_regfile_seq;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   regfile_seq_if bus();
   regfile_seq #(.PC_STEP(2)) dut (.clk(clk), .reset(reset), .bus(bus));

   // Register file model with a bench-only preload port used while the sequencer is idle.
   logic [15:0] rf [8];
   logic        pl_en = 1'b0;
   logic [2:0]  pl_addr = 3'd0;
   logic [15:0] pl_data = 16'h0;
   assign bus.a_in = rf[bus.sela];
   assign bus.b_in = rf[bus.selb];
   always @(posedge clk) begin
      if (bus.we) rf[bus.selb] <= bus.w;
      else if (pl_en) rf[pl_addr] <= pl_data;
   end

   typedef struct {
      string       name;
      logic [15:0] res;
      logic [3:0]  fl;
      int          lat;
      int          wr;
      logic [2:0]  ra;
      logic [15:0] va;
      logic [2:0]  rb;
      logic [15:0] vb;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   s_cyc = 0;
   int   wr_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: counts writes per command and checks each done against the queue head.
   always @(negedge clk) begin
      if (reset) begin
         if (!bus.busy && bus.start) begin
            s_cyc  = cyc + 1;
            wr_cnt = 0;
         end
         if (bus.we) wr_cnt++;
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
               mon_e = exp_q.pop_front();
               chk({mon_e.name, "_result"}, {16'h0, bus.result}, {16'h0, mon_e.res});
               chk({mon_e.name, "_flags"}, {28'h0, bus.flags}, {28'h0, mon_e.fl});
               chk({mon_e.name, "_latency"}, cyc - s_cyc + 1, mon_e.lat);
               chk({mon_e.name, "_writes"}, wr_cnt, mon_e.wr);
               chk({mon_e.name, "_rega"}, {16'h0, rf[mon_e.ra]}, {16'h0, mon_e.va});
               chk({mon_e.name, "_regb"}, {16'h0, rf[mon_e.rb]}, {16'h0, mon_e.vb});
               $display("txn %s: result=%h flags=%b lat=%0d writes=%0d", mon_e.name,
                        bus.result, bus.flags, cyc - s_cyc + 1, wr_cnt);
            end
         end
      end
   end

   task automatic preload(input logic [2:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic run_cmd(input string nm, input logic [2:0] op, input logic [2:0] src,
                          input logic [2:0] dst, input bit poke,
                          input logic [15:0] eres, input logic [3:0] efl, input int elat,
                          input int ewr, input logic [2:0] ra, input logic [15:0] va,
                          input logic [2:0] rb, input logic [15:0] vb);
      exp_t e;
      int   n;
      e.name = nm; e.res = eres; e.fl = efl; e.lat = elat; e.wr = ewr;
      e.ra = ra; e.va = va; e.rb = rb; e.vb = vb;
      exp_q.push_back(e);
      bus.op = op; bus.src = src; bus.dst = dst; bus.start = 1'b1;
      @(posedge clk); #1;
      if (poke) begin
         bus.op = 3'd6; bus.dst = dst;
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      n = 0;
      while (bus.busy && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got busy=1 after 20 cycles expected idle", nm);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 3'd0; bus.src = 3'd0; bus.dst = 3'd0;
      #12;
      chk("rst_sela", {29'h0, bus.sela}, 32'h0);
      chk("rst_selb", {29'h0, bus.selb}, 32'h0);
      chk("rst_we", {31'h0, bus.we}, 32'h0);
      chk("rst_w", {16'h0, bus.w}, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("rst_done", {31'h0, bus.done}, 32'h0);
      chk("rst_result", {16'h0, bus.result}, 32'h0);
      chk("rst_flags", {28'h0, bus.flags}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      preload(3'd7, 16'h0100);
      run_cmd("step", 3'd7, 3'd0, 3'd0, 1'b0, 16'h0000, 4'h0, 2, 1, 3'd7, 16'h0102, 3'd7, 16'h0102);
      preload(3'd1, 16'h7FFF);
      preload(3'd2, 16'h0001);
      run_cmd("add", 3'd1, 3'd1, 3'd2, 1'b0, 16'h8000, 4'hA, 3, 2, 3'd2, 16'h8000, 3'd7, 16'h0104);
      preload(3'd3, 16'h1234);
      preload(3'd4, 16'hABCD);
      run_cmd("swap", 3'd5, 3'd3, 3'd4, 1'b0, 16'hABCD, 4'h0, 4, 3, 3'd4, 16'h1234, 3'd3, 16'hABCD);
      preload(3'd7, 16'h0200);
      run_cmd("mov_pc", 3'd0, 3'd7, 3'd0, 1'b0, 16'h0202, 4'h0, 3, 2, 3'd0, 16'h0202, 3'd7, 16'h0202);
      preload(3'd5, 16'h0000);
      run_cmd("dec2", 3'd4, 3'd0, 3'd5, 1'b1, 16'hFFFE, 4'h9, 3, 2, 3'd5, 16'hFFFE, 3'd7, 16'h0204);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_start_ignored", {31'h0, bus.busy}, 32'h0);
      preload(3'd6, 16'hFFFE);
      run_cmd("inc2_wrap", 3'd3, 3'd0, 3'd6, 1'b0, 16'h0000, 4'h5, 3, 2, 3'd6, 16'h0000, 3'd7, 16'h0206);
      run_cmd("sub_ovf", 3'd2, 3'd1, 3'd2, 1'b0, 16'h0001, 4'h2, 3, 2, 3'd2, 16'h0001, 3'd7, 16'h0208);
      run_cmd("clr", 3'd6, 3'd0, 3'd3, 1'b0, 16'h0000, 4'h4, 3, 2, 3'd3, 16'h0000, 3'd7, 16'h020A);
      run_cmd("swap_same", 3'd5, 3'd4, 3'd4, 1'b0, 16'h1234, 4'h0, 4, 3, 3'd4, 16'h1234, 3'd7, 16'h020C);

      // Abort an ADD while it sits in EXEC.
      bus.op = 3'd1; bus.src = 3'd1; bus.dst = 3'd2; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("abort_pre_we", {31'h0, bus.we}, 32'h1);
      reset = 1'b0;
      #1;
      chk("abort_we", {31'h0, bus.we}, 32'h0);
      chk("abort_busy", {31'h0, bus.busy}, 32'h0);
      chk("abort_result", {16'h0, bus.result}, 32'h0);
      chk("abort_flags", {28'h0, bus.flags}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_dst_kept", {16'h0, rf[2]}, 32'h0001);
      chk("abort_pc", {16'h0, rf[7]}, 32'h020E);
      $display("txn abort_add: we=%b busy=%b r2=%h r7=%h", bus.we, bus.busy, rf[2], rf[7]);
      run_cmd("mov_after_rst", 3'd0, 3'd1, 3'd5, 1'b0, 16'h7FFF, 4'h0, 3, 2, 3'd5, 16'h7FFF, 3'd7, 16'h0210);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end
endmodule
